byte_cmd_responder: RTL and testbench
=====================================

BYTE_CMD_RESPONDER -- requirements
Module: byte_cmd_responder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the response FIFO depth in entries (power of two, at least 2).
REQ-002 The block SHALL have parameter REG_INIT, default 8'h00, giving the reset value of the internal 8-bit register.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request byte valid.
REQ-007 req_data  input  8  request byte (command or argument).
REQ-008 req_ready  output  1  block accepts req_data this cycle.
REQ-009 rsp_valid  output  1  response byte available.
REQ-010 rsp_data  output  8  response byte (FIFO head).
REQ-011 rsp_ready  input  1  consumer takes the response byte this cycle.
REQ-012 rsp_count  output  $clog2(FIFO_DEPTH+1)  number of queued responses.
REQ-013 busy  output  1  high when the FSM is not in IDLE or the FIFO is not empty.

Function
REQ-014 A request transfer SHALL occur on a posedge where req_valid && req_ready; a response transfer SHALL occur on a posedge where rsp_valid && rsp_ready.
REQ-015 The FSM SHALL have three states:
- IDLE: waits for the command byte.
- ARG: waits for the argument byte.
- EXEC: computes and pushes the response.
REQ-016 Transitions SHALL be:
- IDLE to ARG on a request transfer, latching op = req_data[1:0]; bits [7:2] are ignored.
- ARG to EXEC on a request transfer, latching arg = req_data.
- EXEC to IDLE unconditionally after one cycle.
REQ-017 Opcodes SHALL behave as follows (all arithmetic modulo 256, carry discarded):
- 2'b00 ECHO: response = arg.
- 2'b01 ADD: response = arg + reg.
- 2'b10 WRITE: response = old reg; reg <= arg.
- 2'b11 READ: response = reg; arg is ignored.
REQ-018 In EXEC, the response SHALL be pushed into the FIFO and any register update SHALL commit on the same edge.
REQ-019 req_ready SHALL be 1 in IDLE, 0 in EXEC, and in ARG equal to (rsp_count < FIFO_DEPTH).
REQ-020 Latency: with an empty FIFO, an argument accepted at edge N SHALL produce rsp_valid=1 with the result on rsp_data immediately after edge N+1.
REQ-021 rsp_valid SHALL equal (rsp_count != 0); rsp_data SHALL be the oldest queued response and SHALL be 8'h00 when the FIFO is empty.
REQ-022 rsp_data and rsp_valid SHALL hold stable while rsp_valid && !rsp_ready.
REQ-023 A push and a pop on the same edge SHALL leave rsp_count unchanged and preserve FIFO order.
REQ-024 The FIFO SHALL never overflow, because REQ-019 blocks an argument while the FIFO is full.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 A pop with rsp_valid=0 SHALL have no effect.
REQ-027 req_valid held high across IDLE and ARG SHALL consume consecutive bytes, one per ready cycle.

Reset
REQ-028 When rst=1 at a posedge, the block SHALL apply the following values, overriding any simultaneous transfer:
- FSM state: IDLE.
- FIFO: empty, pointers cleared.
- reg: REG_INIT.
- rsp_count: 0; rsp_valid: 0; rsp_data: 8'h00; busy: 0; req_ready: 1.
REQ-029 A reset arriving mid-command (in ARG or EXEC) SHALL discard the partial command and all queued responses, with no register update.

Verification
REQ-030 Reset, then command 8'h00 followed by argument 8'h34 with rsp_ready=1 -> rsp_valid pulses once with rsp_data=8'h34, one cycle after the argument is accepted.
REQ-031 WRITE 8'h56, then ADD 8'hAA, then READ 8'h00 -> responses in order: 8'h00, 8'h00, 8'h56. Correction: the ADD response is 8'h56 + 8'hAA = 8'h00 (wrap), so the full sequence is 8'h00, 8'h00, 8'h56.
REQ-032 rsp_ready=0 with four ECHO commands issued (args 8'h12, 8'h78, 8'h9A, 8'hBC) -> rsp_count=4 and req_ready=0 in ARG on the fifth command; then rsp_ready=1 -> responses drain in order, and the fifth argument is accepted once rsp_count is 3.
REQ-033 Simultaneous push and pop with rsp_count=2 -> rsp_count stays 2 and the order is preserved.
REQ-034 WRITE 8'hDD, then rst asserted while in ARG of a following command -> all outputs return to reset values, and READ afterwards returns REG_INIT.
REQ-035 Command bytes 8'hFC and 8'h00 decode identically as ECHO, and rsp_valid holds stable under backpressure.

Source files
------------

// File: rtl/byte_cmd_responder.sv
// byte_cmd_responder: two-byte command decoder with an 8-bit register and a response FIFO
module byte_cmd_responder #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] REG_INIT   = 8'h00
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    input  logic [7:0]                      req_data,
    output logic                            req_ready,
    output logic                            rsp_valid,
    output logic [7:0]                      rsp_data,
    input  logic                            rsp_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rsp_count,
    output logic                            busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARG, EXEC} state_t;

    state_t         state, state_nxt;
    logic [1:0]     op;
    logic [7:0]     arg;
    logic [7:0]     reg_q;
    logic [7:0]     result;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           req_fire, push, pop;

    assign req_ready = (state == IDLE) || ((state == ARG) && (count < DEPTH_C));
    assign req_fire  = req_valid && req_ready;
    assign push      = (state == EXEC);
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? mem[rd_ptr] : 8'h00;
    assign rsp_count = count;
    assign busy      = (state != IDLE) || rsp_valid;

    // next state and the opcode result (WRITE and READ both answer with the current register)
    always_comb begin
        state_nxt = state;
        result    = (op == 2'b00) ? arg : (op == 2'b01) ? arg + reg_q : reg_q;
        case (state)
            IDLE:    state_nxt = req_fire ? ARG : IDLE;
            ARG:     state_nxt = req_fire ? EXEC : ARG;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // latch opcode from the command byte and operand from the argument byte
    always_ff @(posedge clk) begin
        if (rst) begin
            op  <= 2'b00;
            arg <= 8'h00;
        end else begin
            if (req_fire && state == IDLE) op  <= req_data[1:0];
            if (req_fire && state == ARG)  arg <= req_data;
        end
    end

    // register update commits on the same edge the WRITE response is pushed
    always_ff @(posedge clk) begin
        if (rst)                         reg_q <= REG_INIT;
        else if (push && op == 2'b10)    reg_q <= arg;
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= result;
    end

    // FIFO pointers and occupancy; ARG back-pressure guarantees push never hits a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_byte_cmd_responder.sv
// tb_byte_cmd_responder: directed and random stimulus checked against a queue-based reference model
module tb_byte_cmd_responder;
    localparam int         DEPTH = 4;
    localparam logic [7:0] INIT  = 8'h5A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready = 1'b0;
    logic [2:0] rsp_count;
    logic       busy;

    byte_cmd_responder #(.FIFO_DEPTH(DEPTH), .REG_INIT(INIT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .rsp_count(rsp_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         passes = 0;
    int         m_phase = 0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_arg = 8'h00;
    logic [7:0] m_reg = INIT;
    logic [7:0] q[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] seen_data;
    logic       accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge(input logic exp_ready);
        logic [7:0] res;
        accepted = 1'b0;
        if (rst) begin
            m_phase = 0;
            q.delete();
            m_reg = INIT;
            return;
        end
        if (q.size() != 0 && rsp_ready) begin
            void'(q.pop_front());
            got.push_back(seen_data);
        end
        if (m_phase == 2) begin
            case (m_op)
                2'b00:   res = m_arg;
                2'b01:   res = m_arg + m_reg;
                2'b10:   begin res = m_reg; m_reg = m_arg; end
                default: res = m_reg;
            endcase
            q.push_back(res);
            m_phase = 0;
        end else if (req_valid && exp_ready) begin
            accepted = 1'b1;
            if (m_phase == 0) begin m_op = req_data[1:0]; m_phase = 1; end
            else begin m_arg = req_data; m_phase = 2; end
        end
    endtask

    task automatic cycle();
        logic exp_ready;
        exp_ready = (m_phase == 0) ? 1'b1 : (m_phase == 1) ? (q.size() < DEPTH) : 1'b0;
        #1;
        seen_data = rsp_data;
        check("req_ready", req_ready, exp_ready);
        check("rsp_valid", rsp_valid, q.size() != 0);
        check("rsp_data", rsp_data, q.size() != 0 ? q[0] : 8'h00);
        check("rsp_count", rsp_count, q.size());
        check("busy", busy, (m_phase != 0) || (q.size() != 0));
        @(posedge clk);
        model_edge(exp_ready);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_data  = b;
        accepted  = 1'b0;
        while (!accepted && n < 50) begin
            cycle();
            n++;
        end
        if (!accepted) check("send_timeout", n, 0);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        repeat (8) cycle();
    endtask

    task automatic check_got(input string tag);
        check({tag, "_n"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, i < got.size() ? {24'h0, got[i]} : 32'hFFFF_FFFF, exp_q[i]);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_edge(1'b1);
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_data", rsp_data, 8'h00);
        check("rst_count", rsp_count, 0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        rsp_ready = 1'b1;
        send(8'h00);
        send(8'h34);
        cycle();
        #1;
        check("echo_valid", rsp_valid, 1'b1);
        check("echo_data", rsp_data, 8'h34);
        cycle();
        #1;
        check("echo_once", rsp_valid, 1'b0);
        drain();

        got.delete();
        send(8'h02); send(8'h56);
        send(8'h01); send(8'hAA);
        send(8'h03); send(8'h00);
        drain();
        exp_q = {INIT, 8'h00, 8'h56};
        check_got("wr_add_rd");

        got.delete();
        rsp_ready = 1'b0;
        send(8'h00); send(8'h12);
        send(8'h00); send(8'h78);
        send(8'h00); send(8'h9A);
        send(8'h00); send(8'hBC);
        send(8'h00);
        req_valid = 1'b1;
        req_data  = 8'h55;
        cycle();
        #1;
        check("full_count", rsp_count, 4);
        check("full_block", req_ready, 1'b0);
        rsp_ready = 1'b1;
        send(8'h55);
        drain();
        exp_q = {8'h12, 8'h78, 8'h9A, 8'hBC, 8'h55};
        check_got("full_order");

        got.delete();
        rsp_ready = 1'b0;
        send(8'h00); send(8'hA1);
        send(8'h00); send(8'hA2);
        send(8'h00); send(8'hA3);
        rsp_ready = 1'b1;
        cycle();
        #1;
        check("pushpop_count", rsp_count, 2);
        check("pushpop_head", rsp_data, 8'hA2);
        drain();
        exp_q = {8'hA1, 8'hA2, 8'hA3};
        check_got("pushpop_order");

        rsp_ready = 1'b0;
        send(8'h02); send(8'hDD);
        send(8'h03);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("midrst_count", rsp_count, 0);
        check("midrst_valid", rsp_valid, 1'b0);
        check("midrst_data", rsp_data, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        got.delete();
        send(8'h03); send(8'h00);
        drain();
        exp_q = {INIT};
        check_got("rst_read");

        got.delete();
        rsp_ready = 1'b0;
        send(8'hFC); send(8'h11);
        send(8'h00); send(8'h22);
        repeat (3) begin
            cycle();
            #1;
            check("hold_data", rsp_data, 8'h11);
            check("hold_valid", rsp_valid, 1'b1);
        end
        drain();
        exp_q = {8'h11, 8'h22};
        check_got("fc_echo");

        for (int i = 0; i < 3000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_data  = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        req_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
